// File: rtl/reg_file_sb.sv
// reg_file_sb: parametrised register file with a per-register busy scoreboard.
//
// Provides DEPTH words of WIDTH bits, one write port and two registered read
// ports. A read whose address matches a same-cycle write returns the new data.
// The scoreboard marks a destination pending on reserve and idle on write.
//
// Ports:
//   CLK       rising-edge clock
//   Reset     asynchronous reset, active-low; clears all state
//   wr_en     write strobe; wr_addr / wr_data select target and value
//   rd0_addr  read port 0 address -> rd0_data (registered, 1-cycle latency)
//   rd1_addr  read port 1 address -> rd1_data (registered, 1-cycle latency)
//   busy0/1   combinational scoreboard state for rd0_addr / rd1_addr
//   rsv_en    reserve strobe; rsv_addr selects the destination
//   rsv_err   sticky flag: reserve hit an already-pending register
//
// Optional feature: define RFT_ZERO_REG_EN to hardwire register 0 to zero
// (writes and reserves to address 0 are dropped, busy for address 0 reads 0).

module reg_file_sb #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned ADDR_W = 3,
    parameter int unsigned DEPTH  = 8
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd0_addr,
    output logic [WIDTH-1:0]  rd0_data,
    input  logic [ADDR_W-1:0] rd1_addr,
    output logic [WIDTH-1:0]  rd1_data,
    output logic              busy0,
    output logic              busy1,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic              rsv_err
);

    if (DEPTH != (1 << ADDR_W)) begin : g_bad_depth
        $error("reg_file_sb: DEPTH must equal 2**ADDR_W");
    end

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0] busy_q, busy_d;
    logic [WIDTH-1:0] rd0_q, rd0_d;
    logic [WIDTH-1:0] rd1_q, rd1_d;
    logic             rsv_err_q, rsv_err_d;

    // Effective strobes after the optional zero-register filter.
    logic wr_eff;
    logic rsv_eff;

`ifdef RFT_ZERO_REG_EN
    assign wr_eff  = wr_en && (wr_addr != '0);
    assign rsv_eff = rsv_en && (rsv_addr != '0);
`else
    assign wr_eff  = wr_en;
    assign rsv_eff = rsv_en;
`endif

    always_comb begin
        busy_d    = busy_q;
        rsv_err_d = rsv_err_q;

        // Write retires the producer; a same-cycle reserve re-issues it, so it
        // is applied second and wins.
        if (wr_eff) begin
            busy_d[wr_addr] = 1'b0;
        end
        if (rsv_eff) begin
            busy_d[rsv_addr] = 1'b1;
            if (busy_q[rsv_addr] && !(wr_eff && (wr_addr == rsv_addr))) begin
                rsv_err_d = 1'b1;
            end
        end

        // Bypass: a same-cycle write is forwarded instead of the stale word.
        rd0_d = (wr_eff && (wr_addr == rd0_addr)) ? wr_data : mem_q[rd0_addr];
        rd1_d = (wr_eff && (wr_addr == rd1_addr)) ? wr_data : mem_q[rd1_addr];
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            busy_q    <= '0;
            rd0_q     <= '0;
            rd1_q     <= '0;
            rsv_err_q <= 1'b0;
        end else begin
            if (wr_eff) begin
                mem_q[wr_addr] <= wr_data;
            end
            busy_q    <= busy_d;
            rd0_q     <= rd0_d;
            rd1_q     <= rd1_d;
            rsv_err_q <= rsv_err_d;
        end
    end

    // A same-cycle write clears the hazard, matching the bypass. With the zero
    // register enabled busy_q[0] is never set, so address 0 always reads idle.
    assign busy0 = busy_q[rd0_addr] && !(wr_en && (wr_addr == rd0_addr));
    assign busy1 = busy_q[rd1_addr] && !(wr_en && (wr_addr == rd1_addr));

    assign rd0_data = rd0_q;
    assign rd1_data = rd1_q;
    assign rsv_err  = rsv_err_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: directed self-checking bench for reg_file_sb.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled
// there too, well away from the active edge.

module tb_reg_file_sb;

    logic        CLK;
    logic        Reset;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic [2:0]  rd0_addr;
    logic [15:0] rd0_data;
    logic [2:0]  rd1_addr;
    logic [15:0] rd1_data;
    logic        busy0;
    logic        busy1;
    logic        rsv_en;
    logic [2:0]  rsv_addr;
    logic        rsv_err;

    int n_checks = 0;
    int n_errors = 0;

    reg_file_sb #(
        .WIDTH (16),
        .ADDR_W(3),
        .DEPTH (8)
    ) u_dut (
        .CLK     (CLK),
        .Reset   (Reset),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd0_addr(rd0_addr),
        .rd0_data(rd0_data),
        .rd1_addr(rd1_addr),
        .rd1_data(rd1_data),
        .busy0   (busy0),
        .busy1   (busy1),
        .rsv_en  (rsv_en),
        .rsv_addr(rsv_addr),
        .rsv_err (rsv_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

`ifdef RFT_ZERO_REG_EN
    localparam bit ZeroReg = 1'b1;
`else
    localparam bit ZeroReg = 1'b0;
`endif

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        wr_en  = 1'b0;
        rsv_en = 1'b0;
    endtask

    task automatic do_write(input logic [2:0] a, input logic [15:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
    endtask

    task automatic do_rsv(input logic [2:0] a);
        rsv_en   = 1'b1;
        rsv_addr = a;
    endtask

    task automatic pulse_reset();
        #2;
        Reset = 1'b0;
        step();
        #2;
        Reset = 1'b1;
        step();
    endtask

    initial begin
        Reset    = 1'b0;
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        rd0_addr = '0;
        rd1_addr = '0;
        rsv_en   = 1'b0;
        rsv_addr = '0;
        #12;
        check_eq("reset_rd0", 32'(rd0_data), 32'h0);
        check_eq("reset_rd1", 32'(rd1_data), 32'h0);
        check_eq("reset_err", 32'(rsv_err), 32'h0);
        check_eq("reset_busy0", 32'(busy0), 32'h0);
        @(negedge CLK);
        Reset = 1'b1;
        step();

        // Build mem[3]=0x1234, busy[3]=1, rsv_err=1, then reset mid-cycle.
        do_write(3'd3, 16'h1234);
        step();
        idle();
        do_rsv(3'd3);
        rd0_addr = 3'd3;
        step();
        idle();
        check_eq("pre_rst_rd0", 32'(rd0_data), 32'h1234);
        check_eq("pre_rst_busy0", 32'(busy0), 32'h1);
        do_rsv(3'd3);
        step();
        idle();
        check_eq("pre_rst_err", 32'(rsv_err), 32'h1);
        #2;
        Reset = 1'b0;
        #1;
        check_eq("async_rst_rd0", 32'(rd0_data), 32'h0);
        check_eq("async_rst_err", 32'(rsv_err), 32'h0);
        step();
        #2;
        Reset = 1'b1;
        step();
        check_eq("post_rst_rd0", 32'(rd0_data), 32'h0);
        check_eq("post_rst_busy0", 32'(busy0), 32'h0);

        // Both ports read the same register.
        do_write(3'd5, 16'hBEEF);
        step();
        idle();
        rd0_addr = 3'd5;
        rd1_addr = 3'd5;
        step();
        check_eq("rd0_beef", 32'(rd0_data), 32'hBEEF);
        check_eq("rd1_beef", 32'(rd1_data), 32'hBEEF);

        // Bypass with a pending hazard cleared by the same-cycle write.
        do_write(3'd2, 16'h0001);
        step();
        idle();
        do_rsv(3'd2);
        rd1_addr = 3'd2;
        step();
        idle();
        check_eq("rd1_old", 32'(rd1_data), 32'h0001);
        check_eq("busy1_pend", 32'(busy1), 32'h1);
        do_write(3'd2, 16'hA5A5);
        #1;
        check_eq("busy1_bypass", 32'(busy1), 32'h0);
        step();
        idle();
        check_eq("rd1_bypass", 32'(rd1_data), 32'hA5A5);
        check_eq("busy1_clear", 32'(busy1), 32'h0);

        // Double reserve raises a sticky error; a write clears busy only.
        do_rsv(3'd4);
        rd0_addr = 3'd4;
        step();
        idle();
        check_eq("busy0_rsv4", 32'(busy0), 32'h1);
        check_eq("err_after_first", 32'(rsv_err), 32'h0);
        do_rsv(3'd4);
        step();
        idle();
        check_eq("err_double", 32'(rsv_err), 32'h1);
        check_eq("busy0_still", 32'(busy0), 32'h1);
        step();
        check_eq("err_sticky", 32'(rsv_err), 32'h1);
        do_write(3'd4, 16'h4444);
        step();
        idle();
        check_eq("busy0_wr4", 32'(busy0), 32'h0);
        check_eq("err_sticky_wr", 32'(rsv_err), 32'h1);
        check_eq("rd0_4444", 32'(rd0_data), 32'h4444);

        pulse_reset();
        check_eq("err_cleared", 32'(rsv_err), 32'h0);

        // Reserve and write to the same register: data stored, busy set, no error.
        do_rsv(3'd6);
        rsv_addr = 3'd6;
        wr_en    = 1'b1;
        wr_addr  = 3'd6;
        wr_data  = 16'h0F0F;
        step();
        idle();
        rd0_addr = 3'd6;
        #1;
        check_eq("busy0_rsvwr6", 32'(busy0), 32'h1);
        check_eq("err_rsvwr6", 32'(rsv_err), 32'h0);
        step();
        check_eq("rd0_0f0f", 32'(rd0_data), 32'h0F0F);
        // Second reserve+write on a pending register still raises no error.
        do_rsv(3'd6);
        do_write(3'd6, 16'h6060);
        step();
        idle();
        check_eq("err_rsvwr_busy", 32'(rsv_err), 32'h0);

        // Reserve and write to different registers.
        do_rsv(3'd1);
        do_write(3'd7, 16'h7777);
        step();
        idle();
        rd0_addr = 3'd1;
        rd1_addr = 3'd7;
        #1;
        check_eq("busy0_rsv1", 32'(busy0), 32'h1);
        check_eq("busy1_wr7", 32'(busy1), 32'h0);
        step();
        check_eq("rd1_7777", 32'(rd1_data), 32'h7777);

        // Register 0 behaviour depends on the build.
        rd0_addr = 3'd0;
        do_write(3'd0, 16'hFFFF);
        step();
        idle();
        check_eq("rd0_r0_bypass", 32'(rd0_data), ZeroReg ? 32'h0 : 32'hFFFF);
        step();
        check_eq("rd0_r0_mem", 32'(rd0_data), ZeroReg ? 32'h0 : 32'hFFFF);
        do_rsv(3'd0);
        step();
        idle();
        check_eq("busy0_r0", 32'(busy0), ZeroReg ? 32'h0 : 32'h1);
        check_eq("err_r0_first", 32'(rsv_err), 32'h0);
        do_rsv(3'd0);
        step();
        idle();
        check_eq("err_r0_double", 32'(rsv_err), ZeroReg ? 32'h0 : 32'h1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
Parametrised synchronous register file, the successor to the fixed 32-bit flip-flop word register. It provides DEPTH words of WIDTH bits, two registered read ports with write bypass, and one write port. A per-register busy scoreboard lets the issue stage reserve a destination and detect hazards. It sits in the RFT area, between the decode/issue stage and the writeback stage.

Parameters:
WIDTH, 16, data bits per register
ADDR_W, 3, address bits
DEPTH, 8, number of registers; must equal 2**ADDR_W (compile-time check, elaboration error otherwise)

Ports:
CLK  in  1  rising-edge clock
Reset  in  1  asynchronous reset, active-low
wr_en  in  1  write strobe
wr_addr  in  ADDR_W  write address
wr_data  in  WIDTH  write data
rd0_addr  in  ADDR_W  read port 0 address
rd0_data  out  WIDTH  read port 0 data, registered
rd1_addr  in  ADDR_W  read port 1 address
rd1_data  out  WIDTH  read port 1 data, registered
busy0  out  1  scoreboard busy for rd0_addr, combinational
busy1  out  1  scoreboard busy for rd1_addr, combinational
rsv_en  in  1  reserve destination register
rsv_addr  in  ADDR_W  register to reserve
rsv_err  out  1  sticky: reservation attempted on an already-busy register

Behaviour:
- Reset low, asynchronous, regardless of CLK:
  - all registers go to 0
  - all busy bits go to 0
  - rd0_data and rd1_data go to 0
  - rsv_err goes to 0
- Reset applies immediately mid-operation; the first edge after release behaves normally.
- Write: at a CLK edge with wr_en=1, mem[wr_addr] <= wr_data and busy[wr_addr] <= 0.
- Read: 1-cycle latency; at each edge rdN_data <= mem[rdN_addr].
- Bypass: if wr_en=1 and wr_addr==rdN_addr in the same cycle, rdN_data <= wr_data (the new value, never the stale one).
- Both read ports are independent; both may address the same register.
- busyN = busy[rdN_addr] AND NOT (wr_en AND wr_addr==rdN_addr). A same-cycle write clears the hazard, consistent with the bypass.
- Reserve: at an edge with rsv_en=1, busy[rsv_addr] <= 1.
- Reserve on a register already busy (and not written in the same cycle):
  - busy stays 1
  - rsv_err <= 1
  - rsv_err is sticky until Reset
- Reserve and write to the same address in the same cycle:
  - the write stores its data
  - the reservation wins, so busy ends at 1
  - no rsv_err (the old producer retires as the new one issues)
- Reserve and write to different addresses: both take effect.
- Write to a non-busy register is legal, a plain write with no error.
- Scoreboard state per register is idle (busy=0) or pending (busy=1):
  - idle -> pending on reserve
  - pending -> idle on write
  - pending -> pending on reserve, which raises rsv_err
- No X propagation: all state is reset and all addresses are in range by construction.

Optional Feature:
- Macro RFT_ZERO_REG_EN.
- Defined: register 0 is hardwired to zero.
  - Writes to address 0 are discarded.
  - Reads of address 0 return 0, including via bypass.
  - Reserve of address 0 is ignored: busy[0] stays 0 and rsv_err is never set.
  - busyN is 0 whenever rdN_addr==0.
- Undefined: register 0 is an ordinary register, identical to all others.

Test Plan:
- Reset low mid-traffic with mem[3]=0x1234 and busy[3]=1 -> rd0_data=0 and rsv_err=0 immediately; after release, reading address 3 gives 0x0000 with busy0=0.
- Write 0xBEEF to addr 5, next cycle rd0_addr=5 and rd1_addr=5 -> both read ports show 0xBEEF one edge later.
- Same cycle: wr_en, wr_addr=2, wr_data=0xA5A5, rd1_addr=2 (old value 0x0001) -> rd1_data=0xA5A5 after the edge, busy1=0 during the cycle.
- Reserve addr 4 -> busy0=1 with rd0_addr=4; reserve addr 4 again -> rsv_err=1 and stays 1; write addr 4 -> busy0=0, rsv_err still 1.
- Reserve addr 6 plus write addr 6 (0x0F0F) in the same cycle -> mem[6]=0x0F0F, busy[6]=1, rsv_err=0.
- With RFT_ZERO_REG_EN: write 0xFFFF to addr 0 and reserve addr 0 -> rd0_data=0, busy0=0, rsv_err=0. Without the macro: rd0_data=0xFFFF after the write, and busy0=1 after the reserve.
